// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access stage with lane steering, load extension and fault detection
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Done,
    output logic        Fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    state_t        state;
    logic [1:0]    alo;
    logic [2:0]    f3;
    logic [CW-1:0] cnt;
    logic          req, legal, mis;
    logic [3:0]    be;
    logic [31:0]   wd, sh, ext;
    // request decode, store lane steering, load extraction and stall
    always_comb begin
        req   = MemRead | MemWrite;
        legal = Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        mis   = (Funct3[1:0] == 2'b01 && Addr[0]) || (Funct3[1:0] == 2'b10 && Addr[1:0] != 2'b00);
        be    = Funct3[1:0] == 2'b00 ? 4'b0001 << Addr[1:0] :
                Funct3[1:0] == 2'b01 ? 4'b0011 << {Addr[1], 1'b0} :
                Funct3[1:0] == 2'b10 ? 4'b1111 : 4'b0000;
        wd    = Funct3[1:0] == 2'b00 ? {4{WriteData[7:0]}} :
                Funct3[1:0] == 2'b01 ? {2{WriteData[15:0]}} : WriteData;
        sh    = mem_rdata >> {alo, 3'b000};
        ext   = f3[1:0] == 2'b00 ? {{24{~f3[2] & sh[7]}}, sh[7:0]} :
                f3[1:0] == 2'b01 ? {{16{~f3[2] & sh[15]}}, sh[15:0]} : sh;
        Stall = rst && (state == BUSY || (state == IDLE && req));
    end
    // access FSM with registered bus and completion outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            alo       <= '0;
            f3        <= '0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            Done      <= 1'b0;
            Fault     <= 1'b0;
            ReadData  <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    alo       <= Addr[1:0];
                    f3        <= Funct3;
                    mem_we    <= MemWrite;
                    mem_addr  <= {Addr[31:2], 2'b00};
                    mem_be    <= be;
                    mem_wdata <= wd;
                    cnt       <= '0;
                    if (!legal || mis) begin
                        state    <= DONE;
                        Done     <= 1'b1;
                        Fault    <= 1'b1;
                        ReadData <= '0;
                    end else begin
                        state   <= BUSY;
                        mem_req <= 1'b1;
                    end
                end
                BUSY: if (mem_ready) begin
                    state    <= DONE;
                    mem_req  <= 1'b0;
                    Done     <= 1'b1;
                    ReadData <= mem_we ? 32'h0 : ext;
                end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT)) begin
                    state    <= DONE;
                    mem_req  <= 1'b0;
                    Done     <= 1'b1;
                    Fault    <= 1'b1;
                    ReadData <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    Done     <= 1'b0;
                    Fault    <= 1'b0;
                    ReadData <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage that sits directly downstream of the ALU in the core. It takes the ALU `Result` as the effective address and drives a request/ready memory bus with byte enables. It stalls the core until the access completes, then returns sign- or zero-extended load data to the writeback path. It also flags misaligned accesses, illegal widths and bus timeouts.

## Interface
- `TIMEOUT`, default 255: maximum wait cycles for `mem_ready` after `mem_req` rises; 0 disables the timeout.
- `clk`  in  1  the single core clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `Addr`  in  32  effective address, taken from the ALU `Result`.
- `WriteData`  in  32  store data (rs2).
- `MemRead`  in  1  load request, held by the core while `Stall`=1.
- `MemWrite`  in  1  store request; wins over `MemRead` if both are 1.
- `Funct3`  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU. Any other code is illegal.
- `ReadData`  out  32  extended load result; valid only while `Done`=1.
- `Stall`  out  1  freezes PC and register writes.
- `Done`  out  1  one-cycle completion pulse.
- `Fault`  out  1  one-cycle pulse with `Done`: misaligned, illegal `Funct3`, or timeout.
- `mem_req`  out  1  bus request, registered.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address, {Addr[31:2],2'b00}.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ready`  in  1  bus accept/complete; for reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read word.

## Operation
- FSM states are IDLE, BUSY and DONE.
- **IDLE**, when `MemRead|MemWrite`=1:
  - `Stall`=1 combinationally.
  - Register `Addr[1:0]`, `Funct3`, direction, `mem_addr`, `mem_be` and `mem_wdata`.
  - Legal and aligned: go to BUSY.
  - Illegal `Funct3`, or misaligned (H with Addr[0]=1, W with Addr[1:0]≠0): go to DONE with the fault flag set. No bus transaction is issued.
- **BUSY**:
  - `mem_req`=1; `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` stay stable.
  - Wait counter starts at 0 and increments each cycle.
  - On `mem_ready`=1: capture `mem_rdata` for loads, drop `mem_req`, go to DONE.
  - If `TIMEOUT`≠0 and the counter reaches `TIMEOUT` with no ready: drop `mem_req`, set the fault flag, go to DONE.
- **DONE**:
  - `Done`=1, `Stall`=0, `Fault`=registered flag. The core retires the instruction at this edge.
  - Request inputs are ignored this cycle.
  - Always returns to IDLE.
- **Store lanes**:
  - B: `mem_be`=4'b0001<<Addr[1:0], `mem_wdata`={4{WriteData[7:0]}}.
  - H: `mem_be`=4'b0011<<{Addr[1],1'b0}, `mem_wdata`={2{WriteData[15:0]}}.
  - W: `mem_be`=4'b1111, `mem_wdata`=WriteData.
- **Load extract**:
  - Shift the captured word right by Addr[1:0]×8.
  - B and H sign-extend bit 7 or bit 15; BU and HU zero-extend; W passes through.
  - For loads, `mem_be` shows the accessed lanes; the bus returns the full word.
- **Fault/store cases**: `ReadData`=0 on any fault and on stores.
- **mem_ready outside BUSY**: ignored.

## Timing
- Reset (asynchronous, `rst`=0): FSM goes to IDLE immediately. `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, `Done`, `Fault`, `ReadData` and the internal registers are all 0.
- `Stall`=0 during reset. Reset mid-BUSY drops `mem_req` at once, with no completion.
- Zero-wait access (ready in the first BUSY cycle) takes 3 cycles: IDLE (accept, Stall) → BUSY (req+ready) → DONE (Done).
- Each extra wait cycle adds 1.
- Fault path takes 2 cycles: IDLE → DONE.
- Timeout: DONE follows TIMEOUT+1 BUSY cycles.
- The minimum gap between two accesses is the DONE cycle. A new request is sampled in the IDLE cycle after DONE.
- `Done` and `Fault` are never high outside DONE. `mem_req` is never high outside BUSY.

## Test plan
- LW at Addr=0x100, `mem_ready` high in the first BUSY cycle, `mem_rdata`=0xDEADBEEF:
  - `mem_addr`=0x100, `mem_be`=1111, `mem_req` for 1 cycle.
  - `Done` on cycle 3 with `ReadData`=0xDEADBEEF, `Fault`=0.
- LB, LBU, LH, LHU at Addr=0x203 and 0x202, `mem_rdata`=0x80FF7F01:
  - LB@3 gives 0xFFFFFF80; LBU@3 gives 0x00000080.
  - LH@2 gives 0xFFFF80FF; LHU@2 gives 0x000080FF.
- SB at 0x101 and SH at 0x102 with WriteData=0x12345678:
  - SB: `mem_be`=0010, `mem_wdata`=0x78787878, `mem_we`=1.
  - SH: `mem_be`=1100, `mem_wdata`=0x56785678.
- Misaligned and illegal requests (SW@0x102, LH@0x101, Funct3=011):
  - `mem_req` never rises.
  - `Done` and `Fault` rise on cycle 2; `ReadData`=0.
- Waits and timeout, `TIMEOUT`=4:
  - `mem_ready` delayed 3 cycles: `Stall` held, `mem_*` stable, `Done` 3 cycles later than zero-wait.
  - `mem_ready` never asserted: `mem_req` drops after 5 BUSY cycles, then `Done`=`Fault`=1.
- Async reset asserted mid-BUSY, then released, then an LW:
  - All outputs go to 0 without a clock edge.
  - The following LW completes normally.
